// File: rtl/clock_mode_ctrl_pkg.sv
// Shared constants for the clock front-end: mode encodings, vButton bit
// indices and the helpers that step the mode and gate the button strobes.
package clock_mode_ctrl_pkg;

    // clk_mode encodings, shared with clock_top and the settime/setdate/alarm blocks
    typedef enum logic [1:0] {
        MODE_NORMAL    = 2'd0,
        MODE_SET_TIME  = 2'd1,
        MODE_SET_ALARM = 2'd2,
        MODE_SET_DATE  = 2'd3
    } clk_mode_e;

    // vButton / pButton bit indices
    localparam int BTN_UNITS = 0;
    localparam int BTN_TENS  = 1;
    localparam int BTN_B3    = 2;
    localparam int BTN_AMPM  = 3;
    localparam int NUM_BTN   = 4;

    // Mode key steps NORMAL -> SET_TIME -> SET_ALARM -> SET_DATE -> NORMAL
    function automatic clk_mode_e next_mode(input clk_mode_e m);
        clk_mode_e n;
        case (m)
            MODE_NORMAL:    n = MODE_SET_TIME;
            MODE_SET_TIME:  n = MODE_SET_ALARM;
            MODE_SET_ALARM: n = MODE_SET_DATE;
            default:        n = MODE_NORMAL;
        endcase
        return n;
    endfunction

    // Which button strobes are forwarded in a given mode. Digit keys work in
    // every set mode; am/pm only makes sense for time and alarm.
    function automatic logic [NUM_BTN-1:0] gate_mask(input clk_mode_e m);
        logic [NUM_BTN-1:0] g;
        g = '0;
        if (m != MODE_NORMAL) begin
            g[BTN_UNITS] = 1'b1;
            g[BTN_TENS]  = 1'b1;
            g[BTN_B3]    = 1'b1;
        end
        if (m == MODE_SET_TIME || m == MODE_SET_ALARM) begin
            g[BTN_AMPM] = 1'b1;
        end
        return g;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One raw key: 2-FF synchroniser, counter debounce, registered press strobe.
// The level flips after the synced input has differed from it for
// DEB_CYCLES consecutive mclk; rise pulses for one cycle on a 0->1 flip.
module btn_debounce #(
    parameter int DEB_CYCLES = 4,
    parameter int CW         = 32
) (
    input  logic mclk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          rise_q,  rise_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    // Synchronise, count consecutive disagreeing cycles, flip level at the limit
    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q >= CW'(DEB_CYCLES - 1)) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers, cleared to "released" on reset
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/clock_mode_ctrl.sv
// Front-end controller for clock_top: debounces the four buttons and the
// mode key, steps clk_mode on mode presses, gates button strobes by mode and
// drops back to NORMAL after an idle timeout.
//
//   state          | meaning
//   MODE_NORMAL    | running clock, button strobes dropped, idle counter held at 0
//   MODE_SET_TIME  | editing time, all four buttons forwarded
//   MODE_SET_ALARM | editing alarm, all four buttons forwarded
//   MODE_SET_DATE  | editing date, am/pm button dropped
module clock_mode_ctrl
    import clock_mode_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CW             = 32
) (
    input  logic               mclk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] pButton,
    input  logic               pMode,
    output logic [1:0]         clk_mode,
    output logic [NUM_BTN-1:0] vButton,
    output logic               edit_active,
    output logic               timeout
);

    // Both cycle counts must fit in the CW-bit counters (parameters are int,
    // so any CW of 31 or more is always wide enough).
    localparam bit CW_OK = (CW >= 31) ||
                           ((DEB_CYCLES < (1 << CW)) && (TIMEOUT_CYCLES < (1 << CW)));

    logic [NUM_BTN-1:0] btn_rise;
    logic               mode_rise;
    // Debounced levels are available for hold detection but not consumed here
    logic [NUM_BTN:0]   level_unused;

    clk_mode_e          mode_q, mode_d;
    logic               edit_q, edit_d;
    logic [NUM_BTN-1:0] vbtn_q, vbtn_d;
    logic               tmo_q,  tmo_d;
    logic [CW-1:0]      tcnt_q, tcnt_d;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEB_CYCLES (DEB_CYCLES),
            .CW         (CW)
        ) u_deb (
            .mclk  (mclk),
            .rst   (rst),
            .din   (pButton[i]),
            .level (level_unused[i]),
            .rise  (btn_rise[i])
        );
    end

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .CW         (CW)
    ) u_deb_mode (
        .mclk  (mclk),
        .rst   (rst),
        .din   (pMode),
        .level (level_unused[NUM_BTN]),
        .rise  (mode_rise)
    );

    // Next mode, gated strobes and idle counter; a mode press beats button
    // presses and any press beats the timeout expiry in the same cycle
    always_comb begin
        mode_d = mode_q;
        vbtn_d = '0;
        tmo_d  = 1'b0;
        tcnt_d = tcnt_q;
        if (mode_rise) begin
            mode_d = next_mode(mode_q);
            tcnt_d = '0;
        end else begin
            vbtn_d = btn_rise & gate_mask(mode_q);
            if (mode_q == MODE_NORMAL) begin
                tcnt_d = '0;
            end else if (|btn_rise) begin
                tcnt_d = '0;
            end else if (tcnt_q >= CW'(TIMEOUT_CYCLES - 1)) begin
                mode_d = MODE_NORMAL;
                tmo_d  = 1'b1;
                tcnt_d = '0;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end
        edit_d = (mode_d != MODE_NORMAL);
    end

    // Mode, strobe and counter registers
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            mode_q <= MODE_NORMAL;
            edit_q <= 1'b0;
            vbtn_q <= '0;
            tmo_q  <= 1'b0;
            tcnt_q <= '0;
        end else begin
            mode_q <= mode_d;
            edit_q <= edit_d;
            vbtn_q <= vbtn_d;
            tmo_q  <= tmo_d;
            tcnt_q <= tcnt_d;
        end
    end

    // Flags a counter width too narrow for the chosen cycle counts
    always @(posedge mclk) begin
        assert (CW_OK);
    end

    assign clk_mode    = mode_q;
    assign vButton     = vbtn_q;
    assign edit_active = edit_q;
    assign timeout     = tmo_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl with DEB_CYCLES=4, TIMEOUT_CYCLES=64.
module tb_clock_mode_ctrl;

    logic       mclk;
    logic       rst;
    logic [3:0] pButton;
    logic       pMode;
    logic [1:0] clk_mode;
    logic [3:0] vButton;
    logic       edit_active;
    logic       timeout;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int ev_cyc = 0;
    logic [1:0] cur_mode = 2'd0;

    clock_mode_ctrl #(
        .DEB_CYCLES     (4),
        .TIMEOUT_CYCLES (64),
        .CW             (32)
    ) dut (
        .mclk        (mclk),
        .rst         (rst),
        .pButton     (pButton),
        .pMode       (pMode),
        .clk_mode    (clk_mode),
        .vButton     (vButton),
        .edit_active (edit_active),
        .timeout     (timeout)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    typedef struct {
        logic [3:0] btn;
        logic       mk;
        logic [1:0] exp_mode;
        logic [3:0] exp_vb;
    } vec_t;

    vec_t vecs[15];

    task automatic tick();
        @(posedge mclk);
        #1;
        cyc++;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) tick();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Clean press from pins set now; the registered result lands 7 edges later
    task automatic press(input logic [3:0] b, input logic m,
                         input logic [1:0] em, input logic [3:0] ev);
        pButton = b;
        pMode   = m;
        repeat (6) tick();
        chk("pre_mode", int'(clk_mode), int'(cur_mode));
        chk("pre_vb", int'(vButton), 0);
        tick();
        ev_cyc = cyc;
        chk("mode", int'(clk_mode), int'(em));
        chk("edit", int'(edit_active), (em != 2'd0) ? 1 : 0);
        chk("vb", int'(vButton), int'(ev));
        chk("tmo", int'(timeout), 0);
        tick();
        chk("vb_one_cycle", int'(vButton), 0);
        pButton = 4'b0000;
        pMode   = 1'b0;
        repeat (8) tick();
        chk("release_quiet", int'(vButton), 0);
        cur_mode = em;
    endtask

    initial begin : main
        int e0;
        int p0;
        int c0;
        logic [3:0] seen;

        //            btn      mk    mode   vb
        vecs[0]  = '{4'b0000, 1'b1, 2'd1, 4'b0000};
        vecs[1]  = '{4'b1000, 1'b0, 2'd1, 4'b1000};
        vecs[2]  = '{4'b0001, 1'b0, 2'd1, 4'b0001};
        vecs[3]  = '{4'b0111, 1'b0, 2'd1, 4'b0111};
        vecs[4]  = '{4'b0001, 1'b1, 2'd2, 4'b0000};
        vecs[5]  = '{4'b1000, 1'b0, 2'd2, 4'b1000};
        vecs[6]  = '{4'b0010, 1'b0, 2'd2, 4'b0010};
        vecs[7]  = '{4'b0000, 1'b1, 2'd3, 4'b0000};
        vecs[8]  = '{4'b1000, 1'b0, 2'd3, 4'b0000};
        vecs[9]  = '{4'b0100, 1'b0, 2'd3, 4'b0100};
        vecs[10] = '{4'b1111, 1'b0, 2'd3, 4'b0111};
        vecs[11] = '{4'b0000, 1'b1, 2'd0, 4'b0000};
        vecs[12] = '{4'b0001, 1'b0, 2'd0, 4'b0000};
        vecs[13] = '{4'b1111, 1'b0, 2'd0, 4'b0000};
        vecs[14] = '{4'b1111, 1'b1, 2'd1, 4'b0000};

        rst     = 1'b0;
        pButton = 4'b0000;
        pMode   = 1'b0;
        repeat (3) tick();
        chk("rst_mode", int'(clk_mode), 0);
        chk("rst_vb", int'(vButton), 0);
        chk("rst_edit", int'(edit_active), 0);
        chk("rst_tmo", int'(timeout), 0);
        rst = 1'b1;
        repeat (2) tick();

        // Table: mode stepping, gating, multi-press, simultaneous mode+button
        for (int i = 0; i < 15; i++) begin
            press(vecs[i].btn, vecs[i].mk, vecs[i].exp_mode, vecs[i].exp_vb);
        end
        press(4'b0000, 1'b1, 2'd2, 4'b0000);
        press(4'b0000, 1'b1, 2'd3, 4'b0000);
        press(4'b0000, 1'b1, 2'd0, 4'b0000);

        // 3-cycle glitch on the mode key is ignored
        pMode = 1'b1;
        repeat (3) tick();
        pMode = 1'b0;
        repeat (12) tick();
        chk("glitch_mode", int'(clk_mode), 0);

        // 3-cycle glitch on units in SET_TIME gives no strobe
        press(4'b0000, 1'b1, 2'd1, 4'b0000);
        seen = 4'b0000;
        pButton = 4'b0001;
        repeat (3) tick();
        pButton = 4'b0000;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen = seen | vButton;
        end
        chk("glitch_vb", int'(seen), 0);

        // Exactly 4-cycle mode pulse is accepted, entering SET_ALARM
        c0 = cyc;
        pMode = 1'b1;
        wait_cyc(c0 + 4);
        pMode = 1'b0;
        wait_cyc(c0 + 6);
        chk("min_pulse_pre", int'(clk_mode), 1);
        wait_cyc(c0 + 7);
        chk("min_pulse", int'(clk_mode), 2);
        e0 = cyc;

        // Idle timeout 64 cycles after entering SET_ALARM
        wait_cyc(e0 + 63);
        chk("idle_pre_mode", int'(clk_mode), 2);
        chk("idle_pre_tmo", int'(timeout), 0);
        tick();
        chk("idle_mode", int'(clk_mode), 0);
        chk("idle_edit", int'(edit_active), 0);
        chk("idle_tmo", int'(timeout), 1);
        tick();
        chk("idle_tmo_one_cycle", int'(timeout), 0);
        cur_mode = 2'd0;

        // A tens press at idle cycle 40 pushes the exit out
        press(4'b0000, 1'b1, 2'd1, 4'b0000);
        press(4'b0000, 1'b1, 2'd2, 4'b0000);
        e0 = ev_cyc;
        wait_cyc(e0 + 33);
        press(4'b0010, 1'b0, 2'd2, 4'b0010);
        p0 = ev_cyc;
        wait_cyc(e0 + 64);
        chk("defer_mode", int'(clk_mode), 2);
        chk("defer_tmo", int'(timeout), 0);
        wait_cyc(p0 + 63);
        chk("defer_pre_mode", int'(clk_mode), 2);
        tick();
        chk("defer_exit_mode", int'(clk_mode), 0);
        chk("defer_exit_tmo", int'(timeout), 1);
        cur_mode = 2'd0;

        // Button event in the expiry cycle wins over the timeout
        press(4'b0000, 1'b1, 2'd1, 4'b0000);
        e0 = ev_cyc;
        wait_cyc(e0 + 57);
        pButton = 4'b0001;
        wait_cyc(e0 + 63);
        chk("coll_pre_vb", int'(vButton), 0);
        tick();
        chk("coll_mode", int'(clk_mode), 1);
        chk("coll_vb", int'(vButton), 1);
        chk("coll_tmo", int'(timeout), 0);
        tick();
        chk("coll_after_tmo", int'(timeout), 0);
        pButton = 4'b0000;
        wait_cyc(e0 + 127);
        chk("coll_reload_mode", int'(clk_mode), 1);
        tick();
        chk("coll_reload_exit", int'(clk_mode), 0);
        chk("coll_reload_tmo", int'(timeout), 1);
        cur_mode = 2'd0;

        // Async reset in SET_DATE while button3 is held and strobing
        press(4'b0000, 1'b1, 2'd1, 4'b0000);
        press(4'b0000, 1'b1, 2'd2, 4'b0000);
        press(4'b0000, 1'b1, 2'd3, 4'b0000);
        c0 = cyc;
        pButton = 4'b0100;
        wait_cyc(c0 + 7);
        chk("pre_rst_vb", int'(vButton), 4);
        rst = 1'b0;
        #1;
        chk("async_mode", int'(clk_mode), 0);
        chk("async_vb", int'(vButton), 0);
        chk("async_edit", int'(edit_active), 0);
        chk("async_tmo", int'(timeout), 0);
        repeat (3) tick();
        rst = 1'b1;
        seen = 4'b0000;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen = seen | vButton | {2'b00, clk_mode} | {3'b000, timeout};
        end
        chk("held_after_rst", int'(seen), 0);
        cur_mode = 2'd0;
        press(4'b0000, 1'b1, 2'd1, 4'b0000);
        press(4'b0100, 1'b0, 2'd1, 4'b0100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
